// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin sequencer for a shared 2:1 mux.
// Bounded bursts under contention; registered grant, select, enable, data.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s,
  output logic             enb,
  output logic [WIDTH-1:0] o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       last_q;
  logic       last_d;
  logic       s_d;
  logic       gnt0_d;
  logic       gnt1_d;
  logic       enb_d;
  logic       burst_done;
  logic       enter;

  assign burst_done = (cnt_q == CNT_MAX);

  // Next-state arbitration: round-robin ties, forced hand-off at burst limit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && !req1)
          state_d = GRANT0;
        else if (req1 && !req0)
          state_d = GRANT1;
        else if (req0 && req1)
          state_d = last_q ? GRANT0 : GRANT1;
      end
      GRANT0: begin
        if (!req0)
          state_d = req1 ? GRANT1 : IDLE;
        else if (req1 && burst_done)
          state_d = GRANT1;
      end
      GRANT1: begin
        if (!req1)
          state_d = req0 ? GRANT0 : IDLE;
        else if (req0 && burst_done)
          state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst counter, last-owner tracking and registered control outputs
  always_comb begin
    enter  = (state_d != state_q) && (state_d != IDLE);
    cnt_d  = cnt_q;
    last_d = last_q;
    if (state_d == IDLE)
      cnt_d = 8'd0;
    else if (enter)
      cnt_d = 8'd0;
    else if (!burst_done)
      cnt_d = cnt_q + 8'd1;
    if (enter)
      last_d = (state_d == GRANT1);
    gnt0_d = (state_d == GRANT0);
    gnt1_d = (state_d == GRANT1);
    enb_d  = gnt0_d | gnt1_d;
    s_d    = s;
    if (gnt1_d)
      s_d = 1'b1;
    else if (gnt0_d)
      s_d = 1'b0;
  end

  // State, counter and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      s       <= 1'b0;
      enb     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      s       <= s_d;
      enb     <= enb_d;
    end
  end

  // Data register driven by the current (pre-edge) select and enable
  always_ff @(posedge clk) begin
    if (rst)
      o <= '0;
    else if (enb)
      o <= s ? b : a;
    else
      o <= '0;
  end

endmodule
